mux_4x_rr_arbiter: RTL and testbench
====================================

# mux_4x_rr_arbiter

Round-robin arbiter and output stage that shares one `mux_4x_nbit1` instance between four requesters. Each cycle it picks a winner among active requests, drives the mux `sel`, and captures the mux output into a registered valid/ready output port. Per-requester bursts are bounded so no requester can hold the mux indefinitely. It sits directly in front of the 4:1 mux datapath and behind the downstream consumer.

## Interface
- `BUS_WIDTH`, 8, data width; must match the mux instance.
- `MAX_BURST`, 2, max consecutive grants to one requester while others wait; legal range 1..15.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req`  in  4  request vector; bit i = requester i (mux inputs a,b,c,d = 0,1,2,3) has data on its mux input
- `gnt`  out  4  one-hot accept pulse; `gnt[i]`=1 means requester i's data is captured this edge
- `sel`  out  2  select to mux instance
- `mux_y`  in  BUS_WIDTH  mux output `y`
- `out_data`  out  BUS_WIDTH  registered output data
- `out_valid`  out  1  `out_data` holds an unconsumed word
- `out_ready`  in  1  consumer accepts `out_data` this edge

## Operation
- Internal state: `owner` (2b, last winner), `burst_cnt` (4b), `out_valid`, `out_data`.
- `load = |req && (!out_valid || out_ready)`; all state changes below happen only on `load` unless stated.
- Winner: if `req[owner]` and `1 <= burst_cnt < MAX_BURST` -> `owner` (burst continues); else first set bit of `req` scanning `owner+1, owner+2, owner+3, owner` (mod 4).
- Work-conserving: when burst limit hit and only `owner` requests, `owner` wins again and `burst_cnt` restarts at 1.
- On load: `out_data <= mux_y`, `out_valid <= 1`, `gnt[winner] = 1`, `owner <= winner`, `burst_cnt <= (winner==owner && burst continued) ? burst_cnt+1 : 1`.
- No load and `out_ready`: `out_valid <= 0`, `out_data` holds.
- `burst_cnt <= 0` on any cycle where `req[owner]==0` (burst broken), unless a load happens that cycle.
- `sel` = winner when `load`, else `owner` (combinational from `req`, state).
- `gnt` combinational; all zeros when no load. At most one bit set.
- Requester contract: hold data on its mux input while `req` high; may drop `req` any time before `gnt` with no side effect.

## Timing
- Reset (synchronous, wins over all else): `out_valid`=0, `out_data`=0, `owner`=3, `burst_cnt`=0; hence first scan priority is 0,1,2,3; `gnt`=0 when `req`=0; `sel`=3 when idle.
- Latency: `req` rising with empty output -> `gnt` same cycle -> `out_valid` next cycle.
- Throughput: one word per cycle when `out_ready` held high.
- Backpressure: `out_valid && !out_ready` -> `gnt`=0, `out_data`/`out_valid`/`owner`/`burst_cnt` stable until `out_ready`.
- Simultaneous `out_ready` and new load: old word consumed and new word captured on the same edge, `out_valid` stays 1.
- Reset mid-burst or with `out_valid`=1: held word discarded, no `gnt` on the reset cycle.

## Test plan
- Reset: assert `reset` 2 cycles with `req`=4'hF, `out_ready`=1 -> `gnt`=0 throughout, `out_valid`=0, `out_data`=0; first post-reset cycle `gnt`=4'b0001, `sel`=0.
- Single requester: `req`=4'b0100, mux c=8'h5A, `out_ready`=1 -> `gnt`=4'b0100, `sel`=2, next cycle `out_valid`=1, `out_data`=8'h5A; sustained `req` gives one word/cycle.
- Fairness, MAX_BURST=2: `req`=4'hF held, `out_ready`=1 -> grant sequence 0,0,1,1,2,2,3,3,0,...
- Backpressure: word pending, `out_ready`=0 for 3 cycles with `req`=4'b0011 -> `gnt`=0, `out_data` unchanged; on `out_ready`=1 the next grant follows round-robin order.
- Burst break: owner 1 mid-burst drops `req[1]` one cycle while `req[3]` high -> requester 3 granted; `req[1]` returning is scanned after 3, i.e. 1 is granted next only if 0 is idle.
- Reset mid-operation: assert `reset` with `out_valid`=1, `burst_cnt`=1 -> next cycle `out_valid`=0 and arbitration restarts from requester 0.

Source files
------------

// File: rtl/mux_4x_rr_arbiter.sv
// mux_4x_rr_arbiter
//   Round-robin arbiter and registered output stage in front of a shared
//   4:1 mux (mux_4x_nbit1). Each cycle it picks one active requester, steers
//   the mux through sel, and captures the mux output into a valid/ready
//   output register. A requester keeps the mux for at most MAX_BURST
//   consecutive grants while others are waiting.
//
// Parameters
//   BUS_WIDTH  data width, must match the mux instance
//   MAX_BURST  max back-to-back grants to one requester (1..15)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   req[3:0]   request vector, bit i = mux input i (a,b,c,d = 0..3)
//   gnt[3:0]   one-hot accept pulse, requester's data captured this edge
//   sel[1:0]   select to the mux instance
//   mux_y      mux output
//   out_data   registered output word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer takes out_data this edge
module mux_4x_rr_arbiter #(
  parameter int BUS_WIDTH = 8,
  parameter int MAX_BURST = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  output logic [3:0]           gnt,
  output logic [1:0]           sel,
  input  logic [BUS_WIDTH-1:0] mux_y,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  logic [1:0] owner;
  logic [3:0] burst_cnt;
  logic       load;
  logic       burst_cont;
  logic [1:0] winner;

  // First set bit of r scanning last+1, last+2, last+3, last (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Arbitration (combinational): reset suppresses any grant so the held
  // word is simply discarded on that cycle.
  always_comb begin
    load       = !reset && (|req) && (!out_valid || out_ready);
    burst_cont = req[owner] && (burst_cnt != 4'd0) && (burst_cnt < BURST_LIMIT);
    winner     = burst_cont ? owner : rr_pick(req, owner);
    sel        = load ? winner : owner;
    gnt        = 4'b0000;
    if (load) gnt[winner] = 1'b1;
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      owner     <= 2'd3;
      burst_cnt <= 4'd0;
    end else if (load) begin
      out_data  <= mux_y;
      out_valid <= 1'b1;
      owner     <= winner;
      // A continued burst implies winner == owner; anything else (including
      // the work-conserving re-grant of a lone owner) starts a fresh burst.
      burst_cnt <= burst_cont ? burst_cnt + 4'd1 : 4'd1;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (!req[owner]) burst_cnt <= 4'd0;
    end
  end

endmodule

// File: tb/tb_mux_4x_rr_arbiter.sv
module tb_mux_4x_rr_arbiter;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [BW-1:0] mux_y;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] mdat [4];

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared 4:1 mux.
  assign mux_y = mdat[sel];

  mux_4x_rr_arbiter #(.BUS_WIDTH(BW), .MAX_BURST(2)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .sel(sel),
    .mux_y(mux_y), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] egnt;
    logic [1:0] esel;
  } vec_t;

  localparam int NV = 32;
  vec_t          tbl [NV];
  logic [BW-1:0] sb [$];
  logic          exp_valid;
  logic [BW-1:0] exp_word;
  int            passed = 0;
  int            total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r = 0;
    for (int k = 0; k < 4; k++) if (v[k]) r = k;
    return r;
  endfunction

  initial begin
    // rst, req, rdy, expected gnt, expected sel
    tbl[0]  = '{1'b0, 4'hF,    1'b1, 4'b0001, 2'd0}; // fairness 0,0,1,1,2,2,3,3,0
    tbl[1]  = '{1'b0, 4'hF,    1'b1, 4'b0001, 2'd0};
    tbl[2]  = '{1'b0, 4'hF,    1'b1, 4'b0010, 2'd1};
    tbl[3]  = '{1'b0, 4'hF,    1'b1, 4'b0010, 2'd1};
    tbl[4]  = '{1'b0, 4'hF,    1'b1, 4'b0100, 2'd2};
    tbl[5]  = '{1'b0, 4'hF,    1'b1, 4'b0100, 2'd2};
    tbl[6]  = '{1'b0, 4'hF,    1'b1, 4'b1000, 2'd3};
    tbl[7]  = '{1'b0, 4'hF,    1'b1, 4'b1000, 2'd3};
    tbl[8]  = '{1'b0, 4'hF,    1'b1, 4'b0001, 2'd0};
    tbl[9]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2}; // single requester, 1 word/cycle
    tbl[10] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2};
    tbl[11] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2}; // limit hit, lone owner re-granted
    tbl[12] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2};
    tbl[13] = '{1'b0, 4'b0011, 1'b0, 4'b0000, 2'd2}; // backpressure x3
    tbl[14] = '{1'b0, 4'b0011, 1'b0, 4'b0000, 2'd2};
    tbl[15] = '{1'b0, 4'b0011, 1'b0, 4'b0000, 2'd2};
    tbl[16] = '{1'b0, 4'b0011, 1'b1, 4'b0001, 2'd0}; // released: scan after 2 -> 0
    tbl[17] = '{1'b0, 4'b0011, 1'b1, 4'b0001, 2'd0};
    tbl[18] = '{1'b0, 4'b0011, 1'b1, 4'b0010, 2'd1}; // owner 1, burst 1
    tbl[19] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 2'd3}; // 1 drops -> 3
    tbl[20] = '{1'b0, 4'b0011, 1'b1, 4'b0001, 2'd0}; // 0 before returning 1
    tbl[21] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1}; // 1 granted once 0 idle
    tbl[22] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1}; // idle drains
    tbl[23] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1};
    tbl[24] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1}; // empty output: grant without ready
    tbl[25] = '{1'b0, 4'b0110, 1'b0, 4'b0000, 2'd1};
    tbl[26] = '{1'b0, 4'b0110, 1'b1, 4'b0010, 2'd1}; // consume + capture same edge
    tbl[27] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 2'd3}; // owner 3, burst 1, word held
    tbl[28] = '{1'b1, 4'hF,    1'b1, 4'b0000, 2'd3}; // reset mid-operation
    tbl[29] = '{1'b0, 4'hF,    1'b1, 4'b0001, 2'd0}; // restart from 0
    tbl[30] = '{1'b0, 4'hF,    1'b1, 4'b0001, 2'd0};
    tbl[31] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0}; // drain last word

    // Initial reset held two cycles with all requests active.
    reset = 1'b1; req = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) mdat[i] = 8'($urandom);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("reset%0d_gnt", c), 32'(gnt), 32'h0);
      chk($sformatf("reset%0d_valid", c), 32'(out_valid), 32'h0);
      chk($sformatf("reset%0d_data", c), 32'(out_data), 32'h0);
    end
    exp_valid = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      reset     = tbl[i].rst;
      req       = tbl[i].req;
      out_ready = tbl[i].rdy;
      for (int k = 0; k < 4; k++) mdat[k] = 8'($urandom);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].egnt));
      chk($sformatf("v%0d_sel", i), 32'(sel), 32'(tbl[i].esel));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(exp_valid));
      if (i > 0 && tbl[i-1].rst) chk($sformatf("v%0d_data_after_reset", i), 32'(out_data), 32'h0);
      if (!tbl[i].rst && exp_valid && tbl[i].rdy) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL v%0d_sb: consumption with empty scoreboard, got data %0h", i, out_data);
        end else begin
          exp_word = sb.pop_front();
          chk($sformatf("v%0d_data", i), 32'(out_data), 32'(exp_word));
        end
      end
      if (tbl[i].rst) begin
        sb.delete();
        exp_valid = 1'b0;
      end else if (tbl[i].egnt != 4'b0000) begin
        sb.push_back(mdat[oh_idx(tbl[i].egnt)]);
        exp_valid = 1'b1;
      end else if (tbl[i].rdy) begin
        exp_valid = 1'b0;
      end
    end

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
